// File: rtl/enc_pkg.sv
// Shared definitions for the enc_prio_rr encoder: mode encodings and a
// width helper that never returns zero, so that N=2 still yields a 1-bit code.
package enc_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/enc_prio_scan.sv
// Combinational circular scanner: returns the first set request bit found
// starting at 'start', moving upward (with wrap past N-1) or downward.
module enc_prio_scan
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    input  logic         dir_up,
    output logic [W-1:0] idx,
    output logic         any
);

    int unsigned w_s;
    int unsigned w_p;

    always_comb begin
        idx = '0;
        any = 1'b0;
        w_s = 32'(start);
        w_p = 0;
        for (int unsigned k = 0; k < N; k++) begin
            // start is always < N, so a single conditional wrap is enough
            if (dir_up) begin
                w_p = w_s + k;
                if (w_p >= N) w_p = w_p - N;
            end else begin
                w_p = (w_s >= k) ? (w_s - k) : (w_s + N - k);
            end
            if (!any && req[w_p[W-1:0]]) begin
                any = 1'b1;
                idx = w_p[W-1:0];
            end
        end
    end

endmodule

// File: rtl/enc_prio_rr.sv
// N-to-log2(N) priority encoder, fixed or round-robin, with a registered
// valid/ready output. Define ENC_MULTI_FLAG_EN to add the 'multi' output.
module enc_prio_rr
    import enc_pkg::*;
#(
    parameter  int N = 8,
    localparam int W = clog2_min1(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         mode,
    input  logic [N-1:0] req,
    output logic [W-1:0] code,
    output logic         out_valid,
    input  logic         out_ready
`ifdef ENC_MULTI_FLAG_EN
    ,
    output logic         multi
`endif
);

    logic [W-1:0] r_code;
    logic [W-1:0] r_ptr;
    logic         r_valid;

    logic [W-1:0] w_start;
    logic [W-1:0] w_idx;
    logic         w_any;
    logic         w_dir_up;
    logic         w_slot_free;
    logic         w_capture;

    // One scanner serves both modes: fixed scans down from N-1, RR scans up from ptr
    assign w_dir_up = (mode == MODE_RR);
    assign w_start  = w_dir_up ? r_ptr : W'(N - 1);

    enc_prio_scan #(.N(N)) u_scan (
        .req    (req),
        .start  (w_start),
        .dir_up (w_dir_up),
        .idx    (w_idx),
        .any    (w_any)
    );

    assign w_slot_free = !r_valid || out_ready;
    assign w_capture   = en && w_any && w_slot_free;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_code  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_capture) begin
            r_code  <= w_idx;
            r_valid <= 1'b1;
            if (w_dir_up) begin
                r_ptr <= (w_idx == W'(N - 1)) ? '0 : w_idx + W'(1);
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign code      = r_code;
    assign out_valid = r_valid;

`ifdef ENC_MULTI_FLAG_EN
    logic r_multi;
    logic w_multi;

    // Clearing the lowest set bit leaves something only if two or more were set
    assign w_multi = |(req & (req - N'(1)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_multi <= 1'b0;
        end else if (w_capture) begin
            r_multi <= w_multi;
        end
    end

    assign multi = r_multi;
`endif

endmodule
